// File: rtl/pingpong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pingpong_pkg
// Purpose : Shared types and default sizing for the ping-pong buffer
//           controller: writer/reader state encodings and the default
//           sample width, address width and frame depth.
// Revision: 1.0  initial release
// ============================================================================
package pingpong_pkg;

  // Default sizing: 8-bit samples, 512-sample frames in a 9-bit address space.
  localparam int c_DEF_DW    = 8;
  localparam int c_DEF_AW    = 9;
  localparam int c_DEF_DEPTH = 512;

  // Writer: filling the write-side buffer, or waiting for a swap.
  typedef enum logic [0:0] {
    W_FILL = 1'b0,
    W_DONE = 1'b1
  } wr_state_t;

  // Reader: idle/finished, address phase, data phase.
  typedef enum logic [1:0] {
    R_DONE    = 2'd0,
    R_FETCH   = 2'd1,
    R_PRESENT = 2'd2
  } rd_state_t;

endpackage : pingpong_pkg
`default_nettype wire

// File: rtl/pingpong_rd_seq.sv
`default_nettype none
// ============================================================================
// Module  : pingpong_rd_seq
// Purpose : Frame reader for the ping-pong buffer. After a swap that hands
//           over a complete frame it walks the read side of the buffer and
//           presents each sample as a valid/ready beat, two cycles per beat
//           (address phase, then data phase with the RAM output).
// Ports   : clk, reset          - clock, synchronous active-high reset
//           goodToGo            - swap pulse from the ping-pong buffer
//           i_frame_avail       - a complete frame is available for readout
//           o_frame_take        - pulse: this swap's frame has been claimed
//           r_addr / r_q        - buffer read port (r_q one cycle behind)
//           readDone            - reader needs no more reads
//           out_valid/out_data/out_last/out_ready - readout stream
// Revision: 1.0  initial release
// ============================================================================
module pingpong_rd_seq
  import pingpong_pkg::*;
#(
  parameter int DW    = c_DEF_DW,
  parameter int AW    = c_DEF_AW,
  parameter int DEPTH = c_DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          goodToGo,
  input  logic          i_frame_avail,
  output logic          o_frame_take,
  output logic [AW-1:0] r_addr,
  input  logic [DW-1:0] r_q,
  output logic          readDone,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  rd_state_t       r_state;
  logic [AW-1:0]   r_rcnt;

  // A swap starts a readout only if it actually delivers a written frame.
  assign o_frame_take = (r_state == R_DONE) & goodToGo & i_frame_avail;

  // The RAM output is valid exactly in R_PRESENT, so it is passed straight
  // through; out_valid qualifies it.
  assign out_data = r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_DONE;
      r_rcnt    <= '0;
      r_addr    <= '0;
      readDone  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (r_state)
        R_DONE: begin
          if (o_frame_take) begin
            r_rcnt   <= '0;
            r_addr   <= '0;
            readDone <= 1'b0;
            r_state  <= R_FETCH;
          end
        end
        R_FETCH: begin
          // r_addr has been on the bus for this cycle; data arrives next.
          out_valid <= 1'b1;
          out_last  <= (r_rcnt == c_LAST);
          r_state   <= R_PRESENT;
        end
        R_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              readDone <= 1'b1;
              r_state  <= R_DONE;
            end else begin
              r_rcnt  <= r_rcnt + 1'b1;
              r_addr  <= r_rcnt + 1'b1;
              r_state <= R_FETCH;
            end
          end
        end
        default: begin
          readDone  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          r_state   <= R_DONE;
        end
      endcase
    end
  end

endmodule : pingpong_rd_seq
`default_nettype wire

// File: rtl/pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pingpong_ctrl
// Purpose : Controller between a free-running microphone sample stream and a
//           ping-pong frame buffer. The writer fills one buffer half with
//           DEPTH samples; on each buffer swap the reader streams the just
//           completed frame out while the writer fills the other half.
//           Samples arriving while the writer waits for a swap are dropped
//           and flagged in the sticky overrun output.
// Ports   : clk, reset                  - clock, synchronous active-high reset
//           in_valid / in_data          - sample stream (no backpressure)
//           out_valid/out_data/out_last/out_ready - frame readout stream
//           w_addr / w_data / wren      - buffer write port
//           writeDone                   - writer needs no more writes
//           r_addr / r_q                - buffer read port
//           readDone                    - reader needs no more reads
//           goodToGo                    - swap pulse from the buffer
//           overrun                     - sticky dropped-sample flag
//           overrun_cnt                 - saturating dropped-sample count
//                                         (only with PINGPONG_OVERRUN_CNT_EN)
// Config  : `define PINGPONG_OVERRUN_CNT_EN adds the overrun_cnt output.
// Revision: 1.0  initial release
// ============================================================================
module pingpong_ctrl
  import pingpong_pkg::*;
#(
  parameter int DW    = c_DEF_DW,
  parameter int AW    = c_DEF_AW,
  parameter int DEPTH = c_DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          wren,
  output logic          writeDone,
  output logic [AW-1:0] r_addr,
  input  logic [DW-1:0] r_q,
  output logic          readDone,
  input  logic          goodToGo,
  output logic          overrun
`ifdef PINGPONG_OVERRUN_CNT_EN
  ,
  output logic [15:0]   overrun_cnt
`endif
);

  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  wr_state_t     r_wstate;
  logic [AW-1:0] r_wcnt;
  logic          r_frame_ready;

  logic w_handoff;     // swap accepted by the writer: a full frame changes sides
  logic w_frame_avail; // frame available to the reader on this swap
  logic w_frame_take;  // reader claimed the frame
  logic w_drop;        // sample arriving while the writer cannot store it

  assign w_handoff = (r_wstate == W_DONE) & goodToGo;
  assign w_drop    = (r_wstate == W_DONE) & in_valid;

  // The swap that hands a frame over is the same swap that must start its
  // readout (both done flags fall together), so the reader sees the handoff
  // directly as well as any frame already marked ready. A swap while the
  // writer is still filling (e.g. the power-up pulse) offers nothing.
  assign w_frame_avail = r_frame_ready | w_handoff;

  // --------------------------------------------------------------------------
  // Writer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate  <= W_FILL;
      r_wcnt    <= '0;
      wren      <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      writeDone <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wren <= 1'b0;
      case (r_wstate)
        W_FILL: begin
          if (in_valid) begin
            wren   <= 1'b1;
            w_addr <= r_wcnt;
            w_data <= in_data;
            if (r_wcnt == c_LAST) begin
              r_wstate <= W_DONE;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        W_DONE: begin
          // Raised one cycle after the final write pulse.
          writeDone <= 1'b1;
          if (w_drop) begin
            overrun <= 1'b1;
          end
          if (goodToGo) begin
            r_wcnt    <= '0;
            writeDone <= 1'b0;
            r_wstate  <= W_FILL;
          end
        end
        default: begin
          writeDone <= 1'b0;
          r_wstate  <= W_FILL;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame-ready bookkeeping: set on handoff, cleared when the reader claims
  // the frame. A claim in the same cycle as the handoff wins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_ready <= 1'b0;
    end else if (w_frame_take) begin
      r_frame_ready <= 1'b0;
    end else if (w_handoff) begin
      r_frame_ready <= 1'b1;
    end
  end

`ifdef PINGPONG_OVERRUN_CNT_EN
  logic [15:0] r_ovr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovr_cnt <= '0;
    end else if (w_drop && (r_ovr_cnt != 16'hFFFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end
  end

  assign overrun_cnt = r_ovr_cnt;
`endif

  // --------------------------------------------------------------------------
  // Reader
  // --------------------------------------------------------------------------
  pingpong_rd_seq #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_rd_seq (
    .clk           (clk),
    .reset         (reset),
    .goodToGo      (goodToGo),
    .i_frame_avail (w_frame_avail),
    .o_frame_take  (w_frame_take),
    .r_addr        (r_addr),
    .r_q           (r_q),
    .readDone      (readDone),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_ready     (out_ready)
  );

endmodule : pingpong_ctrl
`default_nettype wire

// File: tb/tb_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pingpong_ctrl
// Purpose : Directed self-checking bench for pingpong_ctrl with a small
//           behavioural two-bank ping-pong buffer attached.
// Config  : follows PINGPONG_OVERRUN_CNT_EN for the overrun_cnt port.
// Revision: 1.0  initial release
// ============================================================================
module tb_pingpong_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          wren;
  logic          writeDone;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_q;
  logic          readDone;
  logic          goodToGo;
  logic          overrun;
`ifdef PINGPONG_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pingpong_ctrl #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .wren      (wren),
    .writeDone (writeDone),
    .r_addr    (r_addr),
    .r_q       (r_q),
    .readDone  (readDone),
    .goodToGo  (goodToGo),
    .overrun   (overrun)
`ifdef PINGPONG_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  // Behavioural ping-pong buffer: writes go to bank[sel], reads come from the
  // other bank with one cycle of latency, every goodToGo swaps the banks.
  logic [DW-1:0] bank [0:1][0:DEPTH-1];
  logic          sel = 1'b0;

  always @(posedge clk) begin
    if (wren) bank[sel][w_addr] <= w_data;
    r_q <= bank[!sel][r_addr];
    if (goodToGo) sel <= !sel;
  end

  function automatic logic [7:0] fdat(input int frame, input int k);
    case (frame)
      1:       return 8'(k);
      2:       return 8'(k * 3 + 1);
      3:       return 8'(255 - k);
      default: return 8'(k ^ 32'h5A);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_sample(input int k, input logic [7:0] d, input bit chk_quiet);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    chk("wr_wren", {31'd0, wren}, 32'd1);
    chk("wr_addr", {23'd0, w_addr}, k);
    chk("wr_data", {24'd0, w_data}, {24'd0, d});
    if (chk_quiet) chk("no_out_valid_before_frame", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  // Reads a whole frame with out_ready held high.
  task automatic rd_frame(input int frame);
    for (int b = 0; b < DEPTH; b++) begin
      wait_valid("rd_valid");
      chk("rd_data", {24'd0, out_data}, {24'd0, fdat(frame, b)});
      chk("rd_last", {31'd0, out_last}, (b == DEPTH - 1) ? 32'd1 : 32'd0);
      tick();
    end
    chk("rd_done_after_frame", {31'd0, readDone}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    goodToGo  = 1'b0;
    tick();
    tick();

    // ---- Reset state
    chk("rst_wren",      {31'd0, wren},      32'd0);
    chk("rst_w_addr",    {23'd0, w_addr},    32'd0);
    chk("rst_w_data",    {24'd0, w_data},    32'd0);
    chk("rst_writeDone", {31'd0, writeDone}, 32'd0);
    chk("rst_readDone",  {31'd0, readDone},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_r_addr",    {23'd0, r_addr},    32'd0);
    chk("rst_overrun",   {31'd0, overrun},   32'd0);
    chk("rst_out_data",  {24'd0, out_data},  {24'd0, r_q});
`ifdef PINGPONG_OVERRUN_CNT_EN
    chk("rst_overrun_cnt", {16'd0, overrun_cnt}, 32'd0);
`endif

    // ---- Power-up swap pulse must be ignored by both sides
    reset    = 1'b0;
    goodToGo = 1'b1;
    tick();
    goodToGo = 1'b0;
    tick();
    chk("pwr_readDone",  {31'd0, readDone},  32'd1);
    chk("pwr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("pwr_writeDone", {31'd0, writeDone}, 32'd0);

    // ---- Frame 1: 512 samples 0..255,0..255
    for (int k = 0; k < DEPTH; k++) wr_sample(k, fdat(1, k), 1'b1);
    chk("f1_writeDone_on_last_wren", {31'd0, writeDone}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("f1_writeDone", {31'd0, writeDone}, 32'd1);
    chk("f1_wren_idle", {31'd0, wren},      32'd0);
    chk("f1_no_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    goodToGo = 1'b1;
    tick();
    goodToGo = 1'b0;
    chk("swap1_writeDone_low", {31'd0, writeDone}, 32'd0);
    chk("swap1_readDone_low",  {31'd0, readDone},  32'd0);
    chk("swap1_fetch_no_valid", {31'd0, out_valid}, 32'd0);

    // ---- Read frame 1 at full rate
    rd_frame(1);

    // ---- Frame 2, then swap with a stalled consumer
    for (int k = 0; k < DEPTH; k++) wr_sample(k, fdat(2, k), 1'b0);
    in_valid = 1'b0;
    tick();
    chk("f2_writeDone", {31'd0, writeDone}, 32'd1);
    out_ready = 1'b0;
    goodToGo  = 1'b1;
    tick();
    goodToGo  = 1'b0;
    tick();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_data",  {24'd0, out_data}, {24'd0, fdat(2, 0)});
    chk("stall_last",  {31'd0, out_last}, 32'd0);

    // Frame 3 fills while the reader is stalled; 10 further samples drop.
    for (int k = 0; k < DEPTH; k++) wr_sample(k, fdat(3, k), 1'b0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hE0 + k);
      tick();
      chk("drop_no_wren", {31'd0, wren}, 32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("ovr_flag",       {31'd0, overrun},   32'd1);
    chk("ovr_writeDone",  {31'd0, writeDone}, 32'd1);
    chk("ovr_readDone",   {31'd0, readDone},  32'd0);
    chk("ovr_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("ovr_hold_data",  {24'd0, out_data}, {24'd0, fdat(2, 0)});
`ifdef PINGPONG_OVERRUN_CNT_EN
    chk("ovr_cnt_10", {16'd0, overrun_cnt}, 32'd10);
`endif

    // ---- Drain frame 2
    out_ready = 1'b1;
    rd_frame(2);

    // ---- Swap with a coincident sample: dropped, next sample lands at 0
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    goodToGo  = 1'b1;
    tick();
    goodToGo  = 1'b0;
    chk("coinc_no_wren",   {31'd0, wren},      32'd0);
    chk("coinc_overrun",   {31'd0, overrun},   32'd1);
    chk("coinc_writeDone", {31'd0, writeDone}, 32'd0);
    chk("coinc_readDone",  {31'd0, readDone},  32'd0);
`ifdef PINGPONG_OVERRUN_CNT_EN
    chk("coinc_cnt_11", {16'd0, overrun_cnt}, 32'd11);
`endif
    for (int k = 0; k < 300; k++) wr_sample(k, fdat(4, k), 1'b0);
    chk("f3_first_valid", {31'd0, out_valid}, 32'd1);
    chk("f3_first_data",  {24'd0, out_data}, {24'd0, fdat(3, 0)});

    // ---- Reset at sample 300
    in_valid = 1'b1;
    in_data  = 8'hC3;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    chk("mrst_wren",      {31'd0, wren},      32'd0);
    chk("mrst_w_addr",    {23'd0, w_addr},    32'd0);
    chk("mrst_writeDone", {31'd0, writeDone}, 32'd0);
    chk("mrst_readDone",  {31'd0, readDone},  32'd1);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_overrun",   {31'd0, overrun},   32'd0);
`ifdef PINGPONG_OVERRUN_CNT_EN
    chk("mrst_cnt", {16'd0, overrun_cnt}, 32'd0);
`endif
    wr_sample(0, 8'h3C, 1'b0);
    in_valid = 1'b0;

    // frame_ready was cleared: a swap now must not start a readout.
    goodToGo = 1'b1;
    tick();
    goodToGo = 1'b0;
    tick();
    chk("mrst_swap_readDone",  {31'd0, readDone},  32'd1);
    chk("mrst_swap_out_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pingpong_ctrl
`default_nettype wire

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 Parameter DW, default 8, sample/data width in bits.
REQ-002 Parameter AW, default 9, buffer address width.
REQ-003 Parameter DEPTH, default 512, samples per frame; legal range 2..2**AW.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_data  in  1 / DW  microphone sample stream; no backpressure.
REQ-007 out_valid / out_data / out_last  out  1 / DW / 1  frame readout stream; out_last marks sample DEPTH-1.
REQ-008 out_ready  in  1  consumer accepts the beat when out_valid & out_ready.
REQ-009 w_addr / w_data / wren  out  AW / DW / 1  write port to the ping-pong buffer.
REQ-010 writeDone  out  1  writer needs no more writes.
REQ-011 r_addr  out  AW  read address to the ping-pong buffer.
REQ-012 r_q  in  DW  read data, valid one cycle after r_addr is presented.
REQ-013 readDone  out  1  reader needs no more reads.
REQ-014 goodToGo  in  1  swap pulse from the ping-pong buffer.
REQ-015 overrun  out  1  sticky flag: one or more samples dropped.

Function
REQ-016 Writer FSM shall have the states W_FILL and W_DONE.
REQ-017 In W_FILL, each in_valid shall register wren=1, w_addr=wcnt, w_data=in_data on the next cycle, then increment wcnt.
REQ-018 The writer shall go to W_DONE after issuing the write at wcnt=DEPTH-1; writeDone shall be 1 from the cycle after that final wren pulse.
REQ-019 In W_DONE, on goodToGo: wcnt=0, go to W_FILL, drop writeDone the next cycle, and set frame_ready.
REQ-020 In W_DONE, an in_valid (including one coincident with goodToGo) shall be dropped and set overrun.
REQ-021 wren shall be 0 whenever no write is being issued; w_addr and w_data hold their last values.
REQ-022 Reader FSM shall have the states R_DONE, R_FETCH and R_PRESENT.
REQ-023 In R_DONE, readDone=1; on goodToGo with frame_ready set: rcnt=0, clear frame_ready, go to R_FETCH.
REQ-024 In R_DONE, goodToGo with frame_ready clear shall be ignored, so the unwritten buffer after power-up is never read out.
REQ-025 R_FETCH shall drive r_addr=rcnt for one cycle with out_valid=0, then go to R_PRESENT.
REQ-026 In R_PRESENT: out_valid=1, out_data=r_q, r_addr held, out_last=(rcnt==DEPTH-1).
REQ-027 On acceptance in R_PRESENT: go to R_DONE if last, else rcnt+1 and go to R_FETCH.
REQ-028 Read throughput shall be one beat per two cycles at most.
REQ-029 readDone shall be 0 in R_FETCH and R_PRESENT.
REQ-030 Both done outputs shall be low in the cycle after goodToGo is acted upon, preventing a double swap.
REQ-031 When goodToGo arrives with the writer in W_FILL, it shall be ignored; this covers the power-up swap.
REQ-032 A slow consumer shall hold the writer in W_DONE; samples arriving in that window shall count as overruns.

Reset
REQ-033 Reset shall give: writer W_FILL, wcnt=0, wren=0, w_addr=0, w_data=0, writeDone=0.
REQ-034 Reset shall give: reader R_DONE, rcnt=0, r_addr=0, readDone=1, out_valid=0, out_last=0, out_data=r_q.
REQ-035 Reset shall give: frame_ready=0, overrun=0, overrun_cnt=0.
REQ-036 Reset mid-frame shall abandon the partial frame with no further wren; the ping-pong buffer itself is not reset.

Configuration
REQ-037 With PINGPONG_OVERRUN_CNT_EN defined: add output overrun_cnt  out  16, counting dropped samples and saturating at 0xFFFF.
REQ-038 Without PINGPONG_OVERRUN_CNT_EN: no overrun_cnt port; overrun flag only.

Structure
REQ-039 Package pingpong_pkg shall hold the wr_state_t and rd_state_t enums and the default DW/AW/DEPTH constants.
REQ-040 The reader FSM shall be sub-module pingpong_rd_seq; the writer FSM, frame_ready and the overrun logic stay in the top level.

Verification
REQ-041 Reset, then 512 in_valid samples 0..255,0..255 -> 512 wren pulses with addr 0..511; writeDone=1 the cycle after the last pulse; goodToGo 2 cycles later.
REQ-042 After the first swap, out_ready=1 -> 512 beats with data matching the written samples, out_last on beat 511, then readDone=1.
REQ-043 Power-up goodToGo at cycle 0 -> no out_valid until the first full frame is written and swapped.
REQ-044 out_ready=0 during the second frame -> writer stalls in W_DONE; 10 extra samples -> overrun=1, overrun_cnt=10 (macro on).
REQ-045 Reset asserted at sample 300 -> wren=0 the next cycle; restart writes at addr 0; frame_ready=0.
REQ-046 in_valid coincident with goodToGo in W_DONE -> sample dropped, overrun=1, first new write at addr 0 with the next sample.
